// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the load/store path of the 5-stage pipeline.
//   mem_state_t   : memory-stage FSM states (IDLE / REQ / WAIT)
//   F3_*          : funct3 encodings of the load/store access widths
//   acc_size_t    : decoded access width
//   access_size() : funct3 -> access width; unknown encodings mean a word
//   misaligned()  : true when the offset is illegal for the access width
// -----------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  // The unsigned encodings only exist for loads; a store carrying 100/101
  // is an undefined encoding and therefore a word access.
  function automatic acc_size_t access_size(input logic is_load, input logic [2:0] f3);
    if (f3 == F3_B || (is_load && f3 == F3_BU)) return SZ_BYTE;
    if (f3 == F3_H || (is_load && f3 == F3_HU)) return SZ_HALF;
    return SZ_WORD;
  endfunction

  function automatic logic misaligned(input acc_size_t sz, input logic [1:0] a);
    return (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a != 2'b00);
  endfunction

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load formatter: picks the addressed byte/halfword out of the
// memory word and sign- or zero-extends it according to funct3.
//   rdata  [31:0] in  : raw word returned by data memory
//   offset [1:0]  in  : byte offset of the access within the word
//   funct3 [2:0]  in  : access width / signedness
//   result [31:0] out : value to write back
// Halfwords use offset[1] only and words ignore the offset, so an unaligned
// access (when not trapped) reads the aligned container.
// -----------------------------------------------------------------------------
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[offset];
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'd0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory stage of the 5-stage pipeline. Non-memory results pass straight to
// write-back one cycle after acceptance. Loads and stores run a
// request/grant(/rvalid) transaction on the data-memory port while ex_ready
// is held low; every accepted instruction yields exactly one wb_valid pulse.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned halfword/word accesses issue no memory request and
//               produce a wb_valid pulse with wb_misalign=1, wb_reg_write=0
//   undefined : wb_misalign stays 0; halfwords use addr[1], words ignore
//               addr[1:0]
//
// Ports
//   clk, rst_n                      : clock, asynchronous active-low reset
//   ex_valid / ex_ready             : upstream handshake (ready = FSM idle)
//   ex_alu_result, ex_store_data    : address / pass-through value, rs2
//   ex_mem_read, ex_mem_write       : load / store (both set = load)
//   ex_funct3, ex_rd, ex_reg_write  : width/sign, destination, write enable
//   dmem_req/we/addr/wdata/be       : registered memory request
//   dmem_gnt, dmem_rvalid, dmem_rdata : memory grant and read response
//   wb_valid/rd/reg_write/data/misalign : one-cycle write-back packet
// -----------------------------------------------------------------------------
module mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_misalign
);

  mem_state_t state_reg, state_next;

  // Decode of the instruction currently offered by execute
  logic       is_mem_op;
  logic       is_load_in;
  logic       misalign_in;
  logic [1:0] a_in;
  acc_size_t  size_in;
  logic [31:0] store_wdata;
  logic [3:0]  store_be;

  // Transaction context captured on acceptance
  logic [1:0] offset_reg;
  logic [2:0] funct3_reg;
  logic [4:0] rd_reg;
  logic       reg_write_reg;
  logic       is_load_reg;

  logic        dmem_we_reg;
  logic [31:0] dmem_addr_reg;
  logic [31:0] dmem_wdata_reg;
  logic [3:0]  dmem_be_reg;

  logic        wb_valid_reg;
  logic [4:0]  wb_rd_reg;
  logic        wb_reg_write_reg;
  logic [31:0] wb_data_reg;
  logic        wb_misalign_reg;

  logic [31:0] load_result;

  assign is_mem_op  = ex_mem_read | ex_mem_write;
  assign is_load_in = ex_mem_read;
  assign a_in       = ex_alu_result[1:0];
  assign size_in    = access_size(is_load_in, ex_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_in = is_mem_op && misaligned(size_in, a_in);
`else
  assign misalign_in = 1'b0;
`endif

  // Store data is replicated into every lane; the byte enables pick the
  // lanes memory actually writes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_store_lane
      assign store_wdata[8*gi +: 8] =
        (size_in == SZ_BYTE) ? ex_store_data[7:0] :
        (size_in == SZ_HALF) ? ex_store_data[8*(gi%2) +: 8] :
                               ex_store_data[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    store_be = 4'b1111;
    case (size_in)
      SZ_BYTE: store_be = 4'b0001 << a_in;
      SZ_HALF: store_be = 4'b0011 << {a_in[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (ex_valid && is_mem_op && !misalign_in) state_next = REQ;
      REQ:  if (dmem_gnt) state_next = is_load_reg ? WAIT : IDLE;
      WAIT: if (dmem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ex_ready = (state_reg == IDLE);
    dmem_req = (state_reg == REQ);
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_reg       <= '0;
      funct3_reg       <= '0;
      rd_reg           <= '0;
      reg_write_reg    <= 1'b0;
      is_load_reg      <= 1'b0;
      dmem_we_reg      <= 1'b0;
      dmem_addr_reg    <= '0;
      dmem_wdata_reg   <= '0;
      dmem_be_reg      <= '0;
      wb_valid_reg     <= 1'b0;
      wb_rd_reg        <= '0;
      wb_reg_write_reg <= 1'b0;
      wb_data_reg      <= '0;
      wb_misalign_reg  <= 1'b0;
    end else begin
      wb_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem_op) begin
              wb_valid_reg     <= 1'b1;
              wb_data_reg      <= ex_alu_result;
              wb_rd_reg        <= ex_rd;
              wb_reg_write_reg <= ex_reg_write;
              wb_misalign_reg  <= 1'b0;
            end else if (misalign_in) begin
              // Faulting address is reported in wb_data for the trap handler
              wb_valid_reg     <= 1'b1;
              wb_data_reg      <= ex_alu_result;
              wb_rd_reg        <= ex_rd;
              wb_reg_write_reg <= 1'b0;
              wb_misalign_reg  <= 1'b1;
            end else begin
              offset_reg     <= a_in;
              funct3_reg     <= ex_funct3;
              rd_reg         <= ex_rd;
              reg_write_reg  <= ex_reg_write;
              is_load_reg    <= is_load_in;
              dmem_we_reg    <= !is_load_in;
              dmem_addr_reg  <= {ex_alu_result[31:2], 2'b00};
              dmem_wdata_reg <= store_wdata;
              // Loads fetch the whole word and align locally
              dmem_be_reg    <= is_load_in ? 4'b1111 : store_be;
            end
          end
        end
        REQ: begin
          if (dmem_gnt && !is_load_reg) begin
            wb_valid_reg     <= 1'b1;
            wb_rd_reg        <= rd_reg;
            wb_reg_write_reg <= 1'b0;
            wb_misalign_reg  <= 1'b0;
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            wb_valid_reg     <= 1'b1;
            wb_data_reg      <= load_result;
            wb_rd_reg        <= rd_reg;
            wb_reg_write_reg <= reg_write_reg;
            wb_misalign_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (offset_reg),
    .funct3 (funct3_reg),
    .result (load_result)
  );

  assign dmem_we      = dmem_we_reg;
  assign dmem_addr    = dmem_addr_reg;
  assign dmem_wdata   = dmem_wdata_reg;
  assign dmem_be      = dmem_be_reg;
  assign wb_valid     = wb_valid_reg;
  assign wb_rd        = wb_rd_reg;
  assign wb_reg_write = wb_reg_write_reg;
  assign wb_data      = wb_data_reg;
  assign wb_misalign  = wb_misalign_reg;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Randomised scoreboard bench for mem_stage. A byte-array model of a 64-byte
// data memory (at 0x100) predicts write-back packets and memory requests; a
// responder process plays the memory with variable grant/rvalid latency and
// a monitor process checks every wb_valid pulse against the expected queue.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_reg_write, wb_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .wb_misalign(wb_misalign)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic        chk_be;
    logic [31:0] wdata;
  } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];
  int       due_q[$];

  logic [31:0] words [16];    // memory seen by the DUT (responder side)
  logic [7:0]  ref_mem [64];  // reference model, byte addressed

  int n_checks = 0;
  int n_fail   = 0;
  int gnt_fix  = -1;
  int rv_fix   = -1;
  bit hold_rv = 1'b0, wait_reached = 1'b0, force_stray = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%08h (cycle %0d)", name, act, cyc);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // Predict the outcome of one instruction from the memory model, then offer
  // it to the DUT and wait for acceptance.
  task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw);
    wb_exp_t w;
    req_exp_t q;
    int sz, a, off, base, t;
    logic [31:0] v;
    bit mis;
    if (f3 == 3'd0 || (mr && f3 == 3'd4)) sz = 1;
    else if (f3 == 3'd1 || (mr && f3 == 3'd5)) sz = 2;
    else sz = 4;
    a    = int'(alu[1:0]);
    off  = (sz == 1) ? a : (sz == 2) ? (a & 2) : 0;
    base = int'(alu[5:0]) & ~3;
    mis  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (mr || mw) && ((a % sz) != 0);
`endif
    w = '{rd: rd, rw: rw, data: alu, chk_data: 1'b1, mis: mis};
    if (mr || mw) begin
      if (mis) begin
        w.rw = 1'b0;
        w.chk_data = 1'b0;
      end else begin
        q = '{addr: {alu[31:2], 2'b00}, we: !mr, be: 4'h0, chk_be: 1'b1, wdata: 32'h0};
        if (!mr) begin
          for (int i = 0; i < sz; i++) begin
            ref_mem[base + off + i] = sd[8*i +: 8];
            q.be[off + i] = 1'b1;
          end
          q.wdata = (sz == 1) ? {4{sd[7:0]}} : (sz == 2) ? {2{sd[15:0]}} : sd;
          w.rw = 1'b0;
          w.chk_data = 1'b0;
        end else begin
          v = 32'h0;
          for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[base + off + i];
          if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
          if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
          w.data = v;
          q.be = 4'hF;
          q.chk_be = (sz == 4);
        end
        req_q.push_back(q);
      end
    end
    wb_q.push_back(w);
    $display("issue rd=%0b wr=%0b f3=%0d alu=0x%08h sd=0x%08h rd=%0d expect=0x%08h mis=%0b",
             mr, mw, f3, alu, sd, rd, w.data, mis);
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3;
    ex_alu_result = alu; ex_store_data = sd; ex_rd = rd; ex_reg_write = rw;
    t = 0;
    while (!ex_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ex_ready) begin
      note_fail("accept_timeout", 32'(t));
      summary();
      $fatal(1, "ex_ready never returned");
    end
    if (!(mr || mw) || mis) due_q.push_back(cyc + 1);
    @(posedge clk);
    #1 ex_valid = 1'b0;
  endtask

  // Memory responder: checks each request, then grants and answers it
  initial begin : responder
    req_exp_t e;
    int d, r, idx;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    logic        we0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (rst_n && dmem_req) begin
        if (req_q.size() == 0) begin
          note_fail("unexpected_req", dmem_addr);
          e = '{addr: dmem_addr, we: dmem_we, be: dmem_be, chk_be: 1'b0, wdata: dmem_wdata};
        end else begin
          e = req_q.pop_front();
        end
        check("req_addr", dmem_addr, e.addr);
        check("req_we", {31'd0, dmem_we}, {31'd0, e.we});
        if (e.we) check("req_wdata", dmem_wdata, e.wdata);
        if (e.chk_be) check("req_be", {28'd0, dmem_be}, {28'd0, e.be});
        check("ready_low_in_req", {31'd0, ex_ready}, 32'd0);
        a0 = dmem_addr; w0 = dmem_wdata; b0 = dmem_be; we0 = dmem_we;
        d = (gnt_fix >= 0) ? gnt_fix : $urandom_range(0, 2);
        repeat (d) begin
          @(negedge clk);
          check("req_held", {26'd0, dmem_req, we0 ^ dmem_we, dmem_be}, {26'd0, 1'b1, 1'b0, b0});
          check("req_addr_stable", dmem_addr, a0);
          check("req_wdata_stable", dmem_wdata, w0);
          check("ready_low_in_req", {31'd0, ex_ready}, 32'd0);
        end
        dmem_gnt = 1'b1;
        idx = int'(a0[5:2]);
        if (we0) begin
          for (int b = 0; b < 4; b++)
            if (b0[b]) words[idx][8*b +: 8] = w0[8*b +: 8];
          due_q.push_back(cyc + 1);
        end else begin
          @(negedge clk);
          dmem_gnt = 1'b0;
          check("req_drop_after_gnt", {31'd0, dmem_req}, 32'd0);
          if (hold_rv) begin
            wait_reached = 1'b1;
          end else begin
            r = (rv_fix >= 0) ? rv_fix : $urandom_range(0, 3);
            repeat (r) @(negedge clk);
            dmem_rvalid = 1'b1;
            dmem_rdata = words[idx];
            due_q.push_back(cyc + 1);
          end
        end
      end else if (rst_n && !hold_rv && (force_stray || $urandom_range(0, 7) == 0)) begin
        // Stray rvalid while no load is outstanding must be ignored
        dmem_rvalid = 1'b1;
        dmem_rdata = $urandom;
      end
    end
  end

  // Write-back monitor
  initial begin : monitor
    wb_exp_t e;
    int due;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid) begin
        if (wb_q.size() == 0) begin
          note_fail("wb_unexpected", wb_data);
        end else begin
          e = wb_q.pop_front();
          check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          check("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
          check("wb_misalign", {31'd0, wb_misalign}, {31'd0, e.mis});
          if (e.chk_data) check("wb_data", wb_data, e.data);
          if (due_q.size() == 0) note_fail("wb_cycle_unscheduled", 32'(cyc));
          else begin
            due = due_q.pop_front();
            check("wb_cycle", 32'(cyc), 32'(due));
          end
          $display("wb    rd=%0d we=%0b mis=%0b data=0x%08h cycle=%0d",
                   wb_rd, wb_reg_write, wb_misalign, wb_data, cyc);
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] w;
    int kind, t;
    logic [2:0] f3;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      words[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_dmem_wdata", dmem_wdata, 32'd0);
    check("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_misalign", {31'd0, wb_misalign}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1);      // ADD
    gnt_fix = 2;
    issue(1'b0, 1'b1, 3'd0, 32'h0000_0103, 32'h0000_00AB, 5'd1, 1'b0); // SB
    gnt_fix = -1;
    issue(1'b0, 1'b1, 3'd2, 32'h0000_0100, 32'h0080_0000, 5'd0, 1'b0); // SW
    issue(1'b1, 1'b0, 3'd0, 32'h0000_0102, 32'h0, 5'd6, 1'b1);        // LB
    issue(1'b1, 1'b0, 3'd4, 32'h0000_0102, 32'h0, 5'd7, 1'b1);        // LBU
    issue(1'b0, 1'b1, 3'd2, 32'h0000_0100, 32'h8001_0000, 5'd0, 1'b0); // SW
    issue(1'b1, 1'b0, 3'd1, 32'h0000_0102, 32'h0, 5'd8, 1'b1);        // LH
    rv_fix = 2;
    issue(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'h0, 5'd9, 1'b1);        // LW, slow rvalid
    rv_fix = -1;
    issue(1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0, 5'd10, 1'b1);       // LW misaligned
    issue(1'b1, 1'b1, 3'd5, 32'h0000_0106, 32'hDEAD_BEEF, 5'd11, 1'b1); // both set = LHU

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      f3 = 3'($urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(kind == 1 || kind == 3, kind == 2 || kind == 3, f3,
            (kind == 0) ? 32'($urandom) : 32'h100 + 32'($urandom_range(0, 63)),
            32'($urandom), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    t = 0;
    while ((wb_q.size() != 0 || req_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_wb_q", 32'(wb_q.size()), 32'd0);
    check("drain_req_q", 32'(req_q.size()), 32'd0);

    // Reset while a load waits for rvalid
    hold_rv = 1'b1;
    wait_reached = 1'b0;
    issue(1'b1, 1'b0, 3'd2, 32'h0000_0108, 32'h0, 5'd12, 1'b1);
    t = 0;
    while (!wait_reached && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("reached_wait", {31'd0, wait_reached}, 32'd1);
    @(negedge clk);
    check("wait_ready_low", {31'd0, ex_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_ex_ready", {31'd0, ex_ready}, 32'd1);
    check("midrst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    wb_q.delete();
    due_q.delete();
    req_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_rv = 1'b0;
    force_stray = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_ready", {31'd0, ex_ready}, 32'd1);
    end
    force_stray = 1'b0;
    repeat (3) @(negedge clk);

    summary();
    $finish;
  end

endmodule
